// File: rtl/ud_sweep_ctrl.sv
// Up/down sweep controller: counts between latched bounds lo..hi with a
// prescaled step rate, optional cycle limit, hold/stop control and 7-seg output.
module ud_sweep_ctrl #(
    parameter int STEP_DIV = 1
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] ncyc,
    output logic       x,
    output logic [3:0] out,
    output logic [6:0] display,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      out_reg, out_next;
    logic [3:0]      lo_reg, lo_next;
    logic [3:0]      hi_reg, hi_next;
    logic [3:0]      ncyc_reg, ncyc_next;
    logic [3:0]      cyc_reg, cyc_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic            accept, reject, step, cycle_end, final_cycle;
    logic [3:0]      cyc_inc;

    // stop outranks start, so neither accept nor reject can fire with it
    assign accept      = (state_reg == IDLE) && start && !stop && (lo <= hi);
    assign reject      = (state_reg == IDLE) && start && !stop && (lo > hi);
    assign step        = (state_reg != IDLE) && !stop && !hold && (presc_reg == PRESC_LAST);
    assign cyc_inc     = cyc_reg + 4'd1;
    assign cycle_end   = step && (state_reg == DOWN) && (out_reg == lo_reg);
    assign final_cycle = cycle_end && (ncyc_reg != 4'd0) && (cyc_inc == ncyc_reg);

    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = UP;
            end
            UP: begin
                if (stop)                              state_next = IDLE;
                else if (step && (out_reg == hi_reg))  state_next = DOWN;
            end
            DOWN: begin
                if (stop)           state_next = IDLE;
                else if (cycle_end) state_next = final_cycle ? IDLE : UP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_next   = out_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        ncyc_next  = ncyc_reg;
        cyc_next   = cyc_reg;
        presc_next = presc_reg;
        done_next  = final_cycle;
        err_next   = reject;
        if (accept) begin
            lo_next    = lo;
            hi_next    = hi;
            ncyc_next  = ncyc;
            out_next   = lo;
            cyc_next   = 4'd0;
            presc_next = '0;
        end else if ((state_reg != IDLE) && !stop && !hold) begin
            presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
        end
        if (step && (state_reg == UP) && (out_reg < hi_reg)) begin
            out_next = out_reg + 4'd1;
        end
        if (step && (state_reg == DOWN)) begin
            if (out_reg > lo_reg) out_next = out_reg - 4'd1;
            else                  cyc_next = cyc_inc;
        end
    end

    always_ff @(posedge cp or negedge reset) begin
        if (!reset) begin
            out_reg   <= 4'd0;
            lo_reg    <= 4'd0;
            hi_reg    <= 4'd0;
            ncyc_reg  <= 4'd0;
            cyc_reg   <= 4'd0;
            presc_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            out_reg   <= out_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            ncyc_reg  <= ncyc_next;
            cyc_reg   <= cyc_next;
            presc_reg <= presc_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Direction is implied by the state: only DOWN reports 0
    always_comb begin
        x    = (state_reg != DOWN);
        busy = (state_reg != IDLE);
        out  = out_reg;
        done = done_reg;
        err  = err_reg;
        case (out_reg)
            4'h0: display = 7'b1111110;
            4'h1: display = 7'b0110000;
            4'h2: display = 7'b1101101;
            4'h3: display = 7'b1111001;
            4'h4: display = 7'b0110011;
            4'h5: display = 7'b1011011;
            4'h6: display = 7'b1011111;
            4'h7: display = 7'b1110000;
            4'h8: display = 7'b1111111;
            4'h9: display = 7'b1111011;
            4'hA: display = 7'b1110111;
            4'hB: display = 7'b0011111;
            4'hC: display = 7'b1001110;
            4'hD: display = 7'b0111101;
            4'hE: display = 7'b1001111;
            default: display = 7'b1000111;
        endcase
    end

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// Bench for ud_sweep_ctrl: two instances (STEP_DIV 1 and 4) share inputs and are
// compared every edge against a behavioural sweep model, plus directed checks.
module tb_ud_sweep_ctrl;

    logic       cp = 1'b0;
    logic       reset, start, stop, hold;
    logic [3:0] lo, hi, ncyc;

    logic       d1_x, d1_busy, d1_done, d1_err;
    logic [3:0] d1_out;
    logic [6:0] d1_disp;
    logic       d4_x, d4_busy, d4_done, d4_err;
    logic [3:0] d4_out;
    logic [6:0] d4_disp;

    int n_tests = 0;
    int n_fail  = 0;

    ud_sweep_ctrl #(.STEP_DIV(1)) dut1 (
        .cp(cp), .reset(reset), .start(start), .stop(stop), .hold(hold),
        .lo(lo), .hi(hi), .ncyc(ncyc),
        .x(d1_x), .out(d1_out), .display(d1_disp), .busy(d1_busy),
        .done(d1_done), .err(d1_err)
    );

    ud_sweep_ctrl #(.STEP_DIV(4)) dut4 (
        .cp(cp), .reset(reset), .start(start), .stop(stop), .hold(hold),
        .lo(lo), .hi(hi), .ncyc(ncyc),
        .x(d4_x), .out(d4_out), .display(d4_disp), .busy(d4_busy),
        .done(d4_done), .err(d4_err)
    );

    always #5 cp = ~cp;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model: running flag, direction, value, bounds, edges since last step, cycles
    int m_div [2] = '{1, 4};
    int m_run [2], m_up [2], m_val [2], m_lo [2], m_hi [2], m_n [2];
    int m_ph [2], m_cyc [2], m_done [2], m_err [2];

    function automatic void model_reset(int i);
        m_run[i] = 0; m_up[i] = 1; m_val[i] = 0; m_lo[i] = 0; m_hi[i] = 0;
        m_n[i] = 0; m_ph[i] = 0; m_cyc[i] = 0; m_done[i] = 0; m_err[i] = 0;
    endfunction

    function automatic void model_edge(int i);
        m_done[i] = 0;
        m_err[i]  = 0;
        if (!reset) begin
            model_reset(i);
            return;
        end
        if (stop) begin
            m_run[i] = 0;
            m_up[i]  = 1;
            return;
        end
        if (m_run[i] == 0) begin
            if (start) begin
                if (lo <= hi) begin
                    m_run[i] = 1; m_up[i] = 1; m_val[i] = int'(lo);
                    m_lo[i] = int'(lo); m_hi[i] = int'(hi); m_n[i] = int'(ncyc);
                    m_ph[i] = 0; m_cyc[i] = 0;
                end else begin
                    m_err[i] = 1;
                end
            end
            return;
        end
        if (hold) return;
        m_ph[i]++;
        if (m_ph[i] < m_div[i]) return;
        m_ph[i] = 0;
        if (m_up[i] == 1) begin
            if (m_val[i] < m_hi[i]) m_val[i]++;
            else                    m_up[i] = 0;
        end else begin
            if (m_val[i] > m_lo[i]) begin
                m_val[i]--;
            end else begin
                m_cyc[i] = (m_cyc[i] + 1) % 16;
                m_up[i]  = 1;
                if (m_n[i] != 0 && m_cyc[i] == m_n[i]) begin
                    m_run[i]  = 0;
                    m_done[i] = 1;
                end
            end
        end
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(string nm, int i, logic ox, logic [3:0] oout, logic [6:0] odisp,
                             logic obusy, logic odone, logic oerr);
        chk($sformatf("%s_out", nm),  int'(oout),  m_val[i]);
        chk($sformatf("%s_x", nm),    int'(ox),    m_up[i]);
        chk($sformatf("%s_busy", nm), int'(obusy), m_run[i]);
        chk($sformatf("%s_done", nm), int'(odone), m_done[i]);
        chk($sformatf("%s_err", nm),  int'(oerr),  m_err[i]);
        chk($sformatf("%s_disp", nm), int'(odisp), int'(seg_tab[m_val[i]]));
    endtask

    task automatic check_all();
        check_dut("div1", 0, d1_x, d1_out, d1_disp, d1_busy, d1_done, d1_err);
        check_dut("div4", 1, d4_x, d4_out, d4_disp, d4_busy, d4_done, d4_err);
    endtask

    task automatic tick();
        @(posedge cp);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    // Called at posedge+1: asserts reset between edges and checks it acts at once
    task automatic async_reset_pulse();
        #3 reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        chk("areset_out", int'(d1_out), 0);
        chk("areset_busy", int'(d1_busy), 0);
        #1 reset = 1'b1;
    endtask

    int seq_out  [7] = '{2, 3, 4, 4, 3, 2, 2};
    int seq_x    [7] = '{1, 1, 1, 0, 0, 0, 1};
    int seq_done [7] = '{0, 0, 0, 0, 0, 0, 1};
    int seq_busy [7] = '{1, 1, 1, 1, 1, 1, 0};

    initial begin
        int save, waits, done_cnt;
        reset = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        lo = 4'd0; hi = 4'd0; ncyc = 4'd0;
        #2;
        model_reset(0);
        model_reset(1);
        check_all();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Basic sweep lo=2 hi=4 ncyc=1
        lo = 4'd2; hi = 4'd4; ncyc = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) tick();
            chk($sformatf("basic_out_%0d", j),  int'(d1_out),  seq_out[j]);
            chk($sformatf("basic_x_%0d", j),    int'(d1_x),    seq_x[j]);
            chk($sformatf("basic_done_%0d", j), int'(d1_done), seq_done[j]);
            chk($sformatf("basic_busy_%0d", j), int'(d1_busy), seq_busy[j]);
        end
        tick();
        chk("basic_done_gone", int'(d1_done), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Bad bounds
        lo = 4'd7; hi = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_err", int'(d1_err), 1);
        chk("bad_busy", int'(d1_busy), 0);
        chk("bad_out", int'(d1_out), 2);
        tick();
        chk("bad_err_gone", int'(d1_err), 0);

        // Hold with prescale 4
        lo = 4'd0; hi = 4'd15; ncyc = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("hold_pre_val", int'(d4_out), 2);
        save = 2;
        hold = 1'b1;
        repeat (10) tick();
        chk("hold_frozen", int'(d4_out), save);
        hold = 1'b0;
        repeat (2) tick();
        chk("hold_phase", int'(d4_out), save);
        tick();
        chk("hold_resume", int'(d4_out), save + 1);
        repeat (4) tick();
        chk("hold_next", int'(d4_out), save + 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Stop + start together mid-DOWN at out=5
        lo = 4'd2; hi = 4'd9; ncyc = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        waits = 0;
        while (!(m_run[0] == 1 && m_up[0] == 0 && m_val[0] == 5) && waits < 60) begin
            tick();
            waits++;
        end
        chk("stop_reach_down5", int'(waits < 60), 1);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop_out", int'(d1_out), 5);
        chk("stop_x", int'(d1_x), 1);
        chk("stop_busy", int'(d1_busy), 0);
        chk("stop_done", int'(d1_done), 0);
        tick();
        chk("stop_idle", int'(d1_busy), 0);

        // Endless full-range run, then asynchronous reset
        lo = 4'd0; hi = 4'd15; ncyc = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        repeat (110) begin
            tick();
            if (d1_done) done_cnt++;
        end
        chk("inf_no_done", done_cnt, 0);
        chk("inf_busy", int'(d1_busy), 1);
        async_reset_pulse();
        tick();

        // Randomized traffic
        repeat (1500) begin
            start = ($urandom_range(3) == 0);
            stop  = ($urandom_range(24) == 0);
            hold  = ($urandom_range(5) == 0);
            lo    = 4'($urandom_range(15));
            hi    = 4'($urandom_range(15));
            ncyc  = 4'($urandom_range(3));
            if ($urandom_range(299) == 0) async_reset_pulse();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
